// File: rtl/nn_pkg.sv
// Shared defaults and FSM state encoding for the NN layer sequencer.
package nn_pkg;

    localparam int NN_CFG_W   = 16;
    localparam int NN_N_CFG   = 4;
    localparam int NN_LAYER_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4
    } seq_state_t;

endpackage

// File: rtl/nn_layer_seq.sv
// Layer sequencer: streams per-layer cfg descriptors into the cfg register
// file, then starts the PE array and waits for completion, once per layer.
module nn_layer_seq
    import nn_pkg::*;
#(
    parameter int CFG_W   = NN_CFG_W,
    parameter int N_CFG   = NN_N_CFG,
    parameter int LAYER_W = NN_LAYER_W,
    localparam int ADDR_W = $clog2(N_CFG)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_go,
    input  logic [LAYER_W-1:0] i_num_layers,
    input  logic               i_desc_valid,
    input  logic [CFG_W-1:0]   i_desc_data,
    output logic               o_desc_ready,
    output logic               o_cfg_wr_en,
    output logic [ADDR_W-1:0]  o_cfg_addr,
    output logic [CFG_W-1:0]   o_cfg_data,
    output logic               o_nn_start,
    input  logic               i_nn_done,
    output logic               o_busy,
    output logic [LAYER_W-1:0] o_layer_idx,
    output logic               o_seq_done
);

    seq_state_t         state_q, state_d;
    logic [ADDR_W-1:0]  word_cnt_q, word_cnt_d;
    logic [LAYER_W-1:0] layer_q, layer_d;
    logic [LAYER_W-1:0] count_q, count_d;
    logic               wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [CFG_W-1:0]   data_q, data_d;
    logic               start_q, start_d;
    logic               busy_q, busy_d;
    logic               seq_done_q, seq_done_d;

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        layer_d    = layer_q;
        count_d    = count_q;
        wr_en_d    = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        start_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_go) begin
                    count_d    = i_num_layers;
                    layer_d    = '0;
                    word_cnt_d = '0;
                    state_d    = (i_num_layers == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (i_desc_valid) begin
                    wr_en_d    = 1'b1;
                    addr_d     = word_cnt_q;
                    data_d     = i_desc_data;
                    word_cnt_d = word_cnt_q + ADDR_W'(1);
                    if (word_cnt_q == ADDR_W'(N_CFG - 1)) begin
                        state_d = START;
                    end
                end
            end
            START: begin
                state_d = RUN;
                start_d = 1'b1;
            end
            RUN: begin
                // A done coincident with our own start pulse belongs to no layer.
                if (i_nn_done && !start_q) begin
                    if (layer_q == count_q - LAYER_W'(1)) begin
                        state_d = DONE;
                    end else begin
                        layer_d = layer_q + LAYER_W'(1);
                        state_d = LOAD;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d     = (state_d != IDLE);
        seq_done_d = (state_d == DONE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            word_cnt_q <= '0;
            layer_q    <= '0;
            count_q    <= '0;
            wr_en_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            seq_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            layer_q    <= layer_d;
            count_q    <= count_d;
            wr_en_q    <= wr_en_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
            seq_done_q <= seq_done_d;
        end
    end

    assign o_desc_ready = (state_q == LOAD);
    assign o_cfg_wr_en  = wr_en_q;
    assign o_cfg_addr   = addr_q;
    assign o_cfg_data   = data_q;
    assign o_nn_start   = start_q;
    assign o_busy       = busy_q;
    assign o_layer_idx  = layer_q;
    assign o_seq_done   = seq_done_q;

endmodule

// File: tb/tb_nn_layer_seq.sv
// Self-checking bench for nn_layer_seq: randomized descriptor streams compared
// against an expected write/start schedule derived from the sequencing rules.
module tb_nn_layer_seq;

    localparam int CFG_W   = 16;
    localparam int N_CFG   = 4;
    localparam int LAYER_W = 8;
    localparam int ADDR_W  = $clog2(N_CFG);

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               go = 1'b0;
    logic [LAYER_W-1:0] num = '0;
    logic               valid = 1'b0;
    logic [CFG_W-1:0]   data = '0;
    logic               done = 1'b0;
    logic               desc_ready;
    logic               cfg_wr_en;
    logic [ADDR_W-1:0]  cfg_addr;
    logic [CFG_W-1:0]   cfg_data;
    logic               nn_start;
    logic               busy;
    logic [LAYER_W-1:0] layer_idx;
    logic               seq_done;

    nn_layer_seq #(.CFG_W(CFG_W), .N_CFG(N_CFG), .LAYER_W(LAYER_W)) dut (
        .i_clk(clk), .i_rst(rst), .i_go(go), .i_num_layers(num),
        .i_desc_valid(valid), .i_desc_data(data), .o_desc_ready(desc_ready),
        .o_cfg_wr_en(cfg_wr_en), .o_cfg_addr(cfg_addr), .o_cfg_data(cfg_data),
        .o_nn_start(nn_start), .i_nn_done(done), .o_busy(busy),
        .o_layer_idx(layer_idx), .o_seq_done(seq_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Observed activity, captured mid-cycle.
    int wr_addr[$];
    int wr_data[$];
    int wr_cyc[$];
    int st_cyc[$];
    int st_layer[$];
    int sd_cyc[$];
    int ready_cnt;

    // Reference: words the bench handed over, in order.
    int exp_data[$];
    int last_done_cyc;
    int busy_at_go;
    bit timed_out;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cfg_wr_en) begin
            wr_addr.push_back(int'(cfg_addr));
            wr_data.push_back(int'(cfg_data));
            wr_cyc.push_back(cyc);
        end
        if (nn_start) begin
            st_cyc.push_back(cyc);
            st_layer.push_back(int'(layer_idx));
        end
        if (seq_done) sd_cyc.push_back(cyc);
        if (desc_ready) ready_cnt++;
    end

    task automatic clear_obs();
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        st_cyc.delete(); st_layer.delete(); sd_cyc.delete();
        exp_data.delete(); ready_cnt = 0; last_done_cyc = -1;
    endtask

    // Drives one full sequence acting as host and PE array.
    task automatic run_seq(input int n, input int gap_pct, input int done_dly,
                           input bit spurious, input bit done_on_start, input bit fixed);
        int launched = 0;
        int cd = -1;
        int total = n * N_CFG;
        #1 clear_obs();
        @(negedge clk);
        go = 1'b1; num = LAYER_W'(n);
        @(negedge clk);
        go = 1'b0;
        busy_at_go = int'(busy);
        timed_out = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (seq_done) begin
                timed_out = 1'b0;
                break;
            end
            valid = 1'b0; done = 1'b0; go = 1'b0;
            if (desc_ready) begin
                if (launched < total && $urandom_range(99) >= gap_pct) begin
                    valid = 1'b1;
                    data = fixed ? CFG_W'(16'h1111 * (launched % N_CFG + 1)) : CFG_W'($urandom);
                    exp_data.push_back(int'(data));
                    launched++;
                end else if (spurious) begin
                    done = 1'b1;
                end
            end else if (spurious) begin
                valid = 1'b1;
                data = CFG_W'($urandom);
            end
            if (nn_start) begin
                cd = done_dly;
                if (done_on_start) done = 1'b1;
            end else if (cd > 0) begin
                cd--;
                if (spurious) begin
                    go = 1'b1; num = LAYER_W'(5);
                end
            end else if (cd == 0) begin
                done = 1'b1;
                cd = -1;
                last_done_cyc = cyc + 1;
            end
            @(negedge clk);
        end
        valid = 1'b0; done = 1'b0; go = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if ({cfg_wr_en, cfg_addr, cfg_data} !== '0) $display("FAIL reset_cfg: got %0h want 0", {cfg_wr_en, cfg_addr, cfg_data}); else n_pass++;
        n_checks++; if ({nn_start, busy, seq_done, desc_ready} !== 4'b0) $display("FAIL reset_ctrl: got %b want 0000", {nn_start, busy, seq_done, desc_ready}); else n_pass++;
        n_checks++; if (layer_idx !== '0) $display("FAIL reset_layer: got %0d want 0", layer_idx); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if ({busy, desc_ready} !== 2'b0) $display("FAIL idle_after_reset: got %b want 00", {busy, desc_ready}); else n_pass++;
    endtask

    task automatic test_single_layer();
        run_seq(1, 0, 5, 1'b0, 1'b0, 1'b1);
        n_checks++; if (timed_out) $display("FAIL single_timeout: got timeout want seq_done"); else n_pass++;
        n_checks++; if (busy_at_go !== 1) $display("FAIL single_busy_go: got %0d want 1", busy_at_go); else n_pass++;
        n_checks++; if (wr_addr.size() !== N_CFG) $display("FAIL single_wr_count: got %0d want %0d", wr_addr.size(), N_CFG);
        else begin
            n_pass++;
            for (int i = 0; i < N_CFG; i++) begin
                n_checks++; if (wr_addr[i] !== i || wr_data[i] !== 16'h1111 * (i + 1))
                    $display("FAIL single_wr%0d: got a=%0d d=%0h want a=%0d d=%0h", i, wr_addr[i], wr_data[i], i, 16'h1111 * (i + 1));
                else n_pass++;
            end
            n_checks++; if (wr_cyc[N_CFG-1] - wr_cyc[0] !== N_CFG - 1) $display("FAIL single_wr_span: got %0d want %0d", wr_cyc[N_CFG-1] - wr_cyc[0], N_CFG - 1); else n_pass++;
            n_checks++; if (st_cyc.size() !== 1 || st_cyc[0] !== wr_cyc[N_CFG-1] + 1)
                $display("FAIL single_start: got n=%0d want one start at %0d", st_cyc.size(), wr_cyc[N_CFG-1] + 1);
            else n_pass++;
        end
        n_checks++; if (sd_cyc.size() !== 1 || sd_cyc[0] !== last_done_cyc)
            $display("FAIL single_seq_done: got n=%0d want one pulse at %0d", sd_cyc.size(), last_done_cyc);
        else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL single_busy_end: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_multi_layer();
        int n = 3;
        run_seq(n, 40, int'($urandom_range(2, 6)), 1'b0, 1'b0, 1'b0);
        n_checks++; if (timed_out) $display("FAIL multi_timeout: got timeout want seq_done"); else n_pass++;
        n_checks++; if (wr_addr.size() !== n * N_CFG || exp_data.size() !== n * N_CFG)
            $display("FAIL multi_wr_count: got %0d want %0d", wr_addr.size(), n * N_CFG);
        else begin
            n_pass++;
            for (int i = 0; i < n * N_CFG; i++) begin
                n_checks++; if (wr_addr[i] !== i % N_CFG || wr_data[i] !== exp_data[i])
                    $display("FAIL multi_wr%0d: got a=%0d d=%0h want a=%0d d=%0h", i, wr_addr[i], wr_data[i], i % N_CFG, exp_data[i]);
                else n_pass++;
            end
            n_checks++; if (st_cyc.size() !== n) $display("FAIL multi_start_count: got %0d want %0d", st_cyc.size(), n);
            else begin
                n_pass++;
                for (int k = 0; k < n; k++) begin
                    n_checks++; if (st_cyc[k] !== wr_cyc[k*N_CFG + N_CFG-1] + 1 || st_layer[k] !== k)
                        $display("FAIL multi_start%0d: got cyc=%0d layer=%0d want cyc=%0d layer=%0d", k, st_cyc[k], st_layer[k], wr_cyc[k*N_CFG + N_CFG-1] + 1, k);
                    else n_pass++;
                end
            end
        end
        n_checks++; if (sd_cyc.size() !== 1) $display("FAIL multi_seq_done: got %0d want 1", sd_cyc.size()); else n_pass++;
    endtask

    task automatic test_zero_layers();
        run_seq(0, 0, 3, 1'b0, 1'b0, 1'b0);
        n_checks++; if (timed_out || sd_cyc.size() !== 1) $display("FAIL zero_seq_done: got %0d pulses want 1", sd_cyc.size()); else n_pass++;
        n_checks++; if (wr_addr.size() !== 0 || st_cyc.size() !== 0)
            $display("FAIL zero_activity: got wr=%0d st=%0d want 0/0", wr_addr.size(), st_cyc.size());
        else n_pass++;
        n_checks++; if (ready_cnt !== 0) $display("FAIL zero_ready: got %0d want 0", ready_cnt); else n_pass++;
    endtask

    task automatic test_spurious();
        run_seq(2, 30, 4, 1'b1, 1'b0, 1'b0);
        n_checks++; if (timed_out) $display("FAIL spur_timeout: got timeout want seq_done"); else n_pass++;
        n_checks++; if (wr_addr.size() !== 2 * N_CFG || st_cyc.size() !== 2)
            $display("FAIL spur_counts: got wr=%0d st=%0d want %0d/2", wr_addr.size(), st_cyc.size(), 2 * N_CFG);
        else begin
            n_pass++;
            for (int i = 0; i < 2 * N_CFG; i++) begin
                n_checks++; if (wr_data[i] !== exp_data[i] || wr_addr[i] !== i % N_CFG)
                    $display("FAIL spur_wr%0d: got a=%0d d=%0h want a=%0d d=%0h", i, wr_addr[i], wr_data[i], i % N_CFG, exp_data[i]);
                else n_pass++;
            end
        end
        n_checks++; if (busy !== 1'b0) $display("FAIL spur_busy_end: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_done_on_start();
        run_seq(2, 0, 3, 1'b0, 1'b1, 1'b0);
        n_checks++; if (timed_out) $display("FAIL dos_timeout: got timeout want seq_done"); else n_pass++;
        n_checks++; if (wr_addr.size() !== 2 * N_CFG || st_cyc.size() !== 2)
            $display("FAIL dos_counts: got wr=%0d st=%0d want %0d/2", wr_addr.size(), st_cyc.size(), 2 * N_CFG);
        else n_pass++;
        n_checks++; if (sd_cyc.size() !== 1 || sd_cyc[0] !== last_done_cyc)
            $display("FAIL dos_seq_done: got n=%0d want one pulse at %0d", sd_cyc.size(), last_done_cyc);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        go = 1'b1; num = LAYER_W'(2);
        @(negedge clk);
        go = 1'b0;
        for (int i = 0; i < 2; i++) begin
            valid = 1'b1; data = CFG_W'($urandom);
            @(negedge clk);
        end
        valid = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++; if ({cfg_wr_en, cfg_addr, cfg_data, nn_start, busy, seq_done, desc_ready, layer_idx} !== '0)
            $display("FAIL midrst_outputs: got %0h want 0", {cfg_wr_en, cfg_addr, cfg_data, nn_start, busy, seq_done, desc_ready, layer_idx});
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        run_seq(1, 20, 2, 1'b0, 1'b0, 1'b0);
        n_checks++; if (timed_out || wr_addr.size() !== N_CFG) $display("FAIL midrst_wr_count: got %0d want %0d", wr_addr.size(), N_CFG);
        else begin
            n_pass++;
            for (int i = 0; i < N_CFG; i++) begin
                n_checks++; if (wr_addr[i] !== i || wr_data[i] !== exp_data[i])
                    $display("FAIL midrst_wr%0d: got a=%0d d=%0h want a=%0d d=%0h", i, wr_addr[i], wr_data[i], i, exp_data[i]);
                else n_pass++;
            end
        end
        n_checks++; if (st_layer.size() !== 1 || st_layer[0] !== 0) $display("FAIL midrst_layer: got n=%0d want one start at layer 0", st_layer.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_layer();
        test_multi_layer();
        test_zero_layers();
        test_spurious();
        test_done_on_start();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
